// File: rtl/ring_injector_q_if.sv
// Node-side bundle of ring_injector_q: ring slots, injection enqueue handshake and status.
interface ring_injector_q_if #(
  parameter int NCH = 2,
  parameter int FW  = 64
);
  logic [NCH*FW-1:0] ring_in;
  logic [NCH*FW-1:0] ring_out;
  logic [NCH-1:0]    enq_valid;
  logic [NCH*FW-1:0] enq_data;
  logic [NCH-1:0]    enq_ready;
  logic [NCH-1:0]    inj_ack;
  logic [NCH-1:0]    starve;
  logic [NCH-1:0]    fifo_empty;

  modport master (
    output ring_in, enq_valid, enq_data,
    input  ring_out, enq_ready, inj_ack, starve, fifo_empty
  );

  modport slave (
    input  ring_in, enq_valid, enq_data,
    output ring_out, enq_ready, inj_ack, starve, fifo_empty
  );
endinterface

// File: rtl/ring_injector_q.sv
// Per-node ring injection stage: per-channel local FIFO whose head fills ring bubbles,
// ring traffic passes combinationally, and a saturating counter flags starved heads.
module ring_injector_q #(
  parameter int NCH       = 2,
  parameter int FW        = 64,
  parameter int VALID_BIT = 63,
  parameter int DEPTH     = 4,
  parameter int CW        = 8,
  parameter int STARVE_TH = 32
) (
  input  logic            clk,
  input  logic            rst,
  ring_injector_q_if.slave bus
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(DEPTH);
  localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_TH);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [FW-1:0]   mem [DEPTH];
      logic [PW-1:0]   rd_ptr;
      logic [PW-1:0]   wr_ptr;
      logic [CNTW-1:0] count;
      logic [CW-1:0]   scnt;
      logic [CW-1:0]   scnt_nxt;
      logic            starve_q;
      logic [FW-1:0]   slot_in;
      logic [FW-1:0]   slot_out;
      logic            rv;
      logic            empty;
      logic            full;
      logic            ack;
      logic            push;

      assign slot_in = bus.ring_in[c*FW +: FW];
      assign rv      = slot_in[VALID_BIT];
      assign empty   = (count == '0);
      assign full    = (count == FULL_CNT);
      assign ack     = ~rv & ~empty;
      // Acceptance looks only at the current count, so a same-cycle pop never frees a full FIFO.
      assign push    = bus.enq_valid[c] & ~rst & ~full;

      always_comb begin
        slot_out = slot_in;
        if (ack) begin
          slot_out            = mem[rd_ptr];
          slot_out[VALID_BIT] = 1'b1;
        end
      end

      always_comb begin
        scnt_nxt = sat_inc(scnt);
        if (empty || ack) scnt_nxt = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr   <= '0;
          wr_ptr   <= '0;
          count    <= '0;
          scnt     <= '0;
          starve_q <= 1'b0;
        end else begin
          if (push) wr_ptr <= ptr_inc(wr_ptr);
          if (ack)  rd_ptr <= ptr_inc(rd_ptr);
          if (push && !ack)      count <= count + 1'b1;
          else if (!push && ack) count <= count - 1'b1;
          scnt     <= scnt_nxt;
          starve_q <= (scnt_nxt >= STARVE_LIM);
        end
      end

      // Flit storage carries no reset; occupancy is governed entirely by the pointers.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.enq_data[c*FW +: FW];
      end

      assign bus.ring_out[c*FW +: FW] = slot_out;
      assign bus.enq_ready[c]         = ~rst & ~full;
      assign bus.inj_ack[c]           = ack;
      assign bus.starve[c]            = starve_q;
      assign bus.fifo_empty[c]        = empty;
    end
  endgenerate

endmodule
